// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: opcode encodings, flag bit positions
// and a helper that packs the four status flags into the registered flag vector.
// Ports: none (package only).
package alu_pkg;

    // Operation select encodings driven by the ALU control decoder
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Bit positions inside the 4-bit flag vector {V, C, N, Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef logic [3:0] flags_t;

    function automatic flags_t pack_flags(input logic v, input logic c,
                                          input logic n, input logic z);
        flags_t f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: one WIDTH-bit adder with operand-B invert and carry-in tied to sub.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs after settle.
// Ports: a, b operands; sub selects a - b; sum, carry_out (carry / no-borrow), overflow (signed).
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // Subtraction is a + ~b + 1, so the carry-out doubles as "no borrow".
    assign b_eff    = sub ? ~b : b;
    assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum       = full_sum[WIDTH-1:0];
    assign carry_out = full_sum[WIDTH];

    // Overflow when the two adder inputs agree in sign but the result does not.
    // Using b_eff covers SUB too: "operands differ in sign" becomes "a and ~b agree".
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Integer ALU (ADD/SUB/OR/AND) with combinational result+flags and a registered copy.
// Latency: data_out/flags zero cycles; res_q/flags_q/out_valid one cycle after in_valid.
// Backpressure: none; in_valid may be asserted every cycle and every beat is captured.
// Ports: clk, rst (sync, active-high), alu_op, data_1, data_2, in_valid ->
//        data_out, zero, negative, carry, overflow (combinational), res_q, flags_q, out_valid (registered).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] res_q,
    output logic [3:0]       flags_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             is_sub;

    assign is_sub = (alu_op == ALU_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a         (data_1),
        .b         (data_2),
        .sub       (is_sub),
        .sum       (as_sum),
        .carry_out (as_carry),
        .overflow  (as_ovf)
    );

    // Opcode mux; logic ops never report carry or overflow.
    always_comb begin
        data_out = as_sum;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                data_out = as_sum;
                carry    = as_carry;
                overflow = as_ovf;
            end
            ALU_OR:  data_out = data_1 | data_2;
            ALU_AND: data_out = data_1 & data_2;
            default: data_out = as_sum;
        endcase
    end

    assign zero     = (data_out == '0);
    assign negative = data_out[WIDTH-1];

    // Registered copy; reset wins over a coincident in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            flags_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q   <= data_out;
                flags_q <= pack_flags(overflow, carry, negative, zero);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    alu_op;
    logic [W-1:0]  data_1;
    logic [W-1:0]  data_2;
    logic          in_valid;
    logic [W-1:0]  data_out;
    logic          zero;
    logic          negative;
    logic          carry;
    logic          overflow;
    logic [W-1:0]  res_q;
    logic [3:0]    flags_q;
    logic          out_valid;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_op    (alu_op),
        .data_1    (data_1),
        .data_2    (data_2),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .res_q     (res_q),
        .flags_q   (flags_q),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   f;
        bit           rnd;
    } exp_t;

    exp_t comb_q[$];
    exp_t reg_q[$];
    event comb_ev;

    int n_cmp     = 0;
    int n_bad     = 0;
    int rand_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req,
                       output bit ok);
        n_cmp++;
        ok = (act === req);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model built from wide arithmetic rather than carry/sign-bit logic.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic [3:0] f);
        logic signed [W:0] ea;
        logic signed [W:0] eb;
        logic signed [W:0] sx;
        logic c;
        logic v;
        ea = {a[W-1], a};
        eb = {b[W-1], b};
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            ALU_ADD: begin
                d  = a + b;
                c  = (d < a);
                sx = ea + eb;
                v  = (sx[W] != sx[W-1]);
            end
            ALU_SUB: begin
                d  = a - b;
                c  = (a >= b);
                sx = ea - eb;
                v  = (sx[W] != sx[W-1]);
            end
            ALU_OR:  d = a | b;
            default: d = a & b;
        endcase
        f = {v, c, d[W-1], (d == '0)};
    endtask

    // Drive one accepted operation at the falling edge and record what both outputs must show.
    task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d, input logic [3:0] exp_f, input bit rnd);
        exp_t e;
        @(negedge clk);
        alu_op   = op;
        data_1   = a;
        data_2   = b;
        in_valid = 1'b1;
        #1;
        e.d = exp_d;
        e.f = exp_f;
        e.rnd = rnd;
        comb_q.push_back(e);
        reg_q.push_back(e);
        -> comb_ev;
    endtask

    // Combinational monitor
    initial begin
        exp_t e;
        bit ok1;
        bit ok2;
        forever begin
            @(comb_ev);
            if (comb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL comb_queue: got empty queue expected an entry");
            end else begin
                e = comb_q.pop_front();
                chk("comb data_out", data_out, e.d, ok1);
                chk("comb flags {v,c,n,z}", {60'd0, overflow, carry, negative, zero},
                    {60'd0, e.f}, ok2);
                if (e.rnd && ok1 && ok2) rand_pass++;
            end
        end
    end

    // Registered-path monitor: pops whenever the DUT presents out_valid
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (reg_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL reg_queue: got unexpected out_valid expected none");
                end else begin
                    e = reg_q.pop_front();
                    chk("res_q", res_q, e.d, ok);
                    chk("flags_q", {60'd0, flags_q}, {60'd0, e.f}, ok);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [3:0]   f;

        rst      = 1'b1;
        in_valid = 1'b0;
        alu_op   = ALU_ADD;
        data_1   = '0;
        data_2   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset res_q", res_q, '0, ok);
        chk("reset flags_q", {60'd0, flags_q}, '0, ok);
        chk("reset out_valid", {63'd0, out_valid}, '0, ok);

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, flags listed as {V,C,N,Z}
        drive(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101, 1'b0);
        drive(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100, 1'b0);
        drive(ALU_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 1'b0);
        drive(ALU_OR,  64'hF0F0, 64'h0FF0, 64'hFFF0, 4'b0000, 1'b0);
        drive(ALU_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 4'b0000, 1'b0);
        drive(ALU_SUB, 64'd7, 64'd7, 64'd0, 4'b0101, 1'b0);
        drive(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010, 1'b0);

        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            model(op, a, b, d, f);
            drive(op, a, b, d, f, 1'b1);
        end

        drive(ALU_ADD, 64'd2, 64'd3, 64'd5, 4'b0000, 1'b0);

        // Hold: no capture while in_valid is low
        @(negedge clk);
        in_valid = 1'b0;
        alu_op   = ALU_OR;
        data_1   = 64'hDEAD;
        data_2   = 64'hBEEF;
        @(posedge clk);
        #1;
        chk("hold res_q", res_q, 64'd5, ok);
        chk("hold flags_q", {60'd0, flags_q}, '0, ok);
        chk("hold out_valid", {63'd0, out_valid}, '0, ok);

        // Reset together with in_valid: reset wins, combinational path unaffected
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        alu_op   = ALU_ADD;
        data_1   = 64'd7;
        data_2   = 64'd8;
        @(posedge clk);
        #1;
        chk("rst+valid res_q", res_q, '0, ok);
        chk("rst+valid flags_q", {60'd0, flags_q}, '0, ok);
        chk("rst+valid out_valid", {63'd0, out_valid}, '0, ok);
        chk("comb during reset", data_out, 64'd15, ok);

        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("comb queue drained", 64'(comb_q.size()), '0, ok);
        chk("reg queue drained", 64'(reg_q.size()), '0, ok);
        $display("random data_out agreement: %0d/100", rand_pass);
        chk("random pass count", 64'(rand_pass), 64'd100, ok);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational 64-bit integer ALU of the single-cycle RISC-V datapath, driven by the ALU control decoder and feeding writeback/branch logic. Computes add, subtract, OR or AND of two operands selected by a 2-bit opcode. Result and status flags are available combinationally in the same cycle. A registered copy is also captured on the clock for pipelined or debug consumers.

## Interface
- `WIDTH`, 64, operand/result width in bits (must be ≥ 2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset; synchronous and active-high
- `alu_op`  input  2  operation select: 00 ADD, 01 SUB, 10 OR, 11 AND
- `data_1`  input  WIDTH  operand A
- `data_2`  input  WIDTH  operand B
- `in_valid`  input  1  capture enable for registered outputs
- `data_out`  output  WIDTH  combinational result
- `zero`  output  1  combinational: `data_out == 0`
- `negative`  output  1  combinational: `data_out[WIDTH-1]`
- `carry`  output  1  combinational carry/no-borrow
- `overflow`  output  1  combinational signed overflow
- `res_q`  output  WIDTH  registered result
- `flags_q`  output  4  registered {overflow, carry, negative, zero}
- `out_valid`  output  1  registered; high one cycle after accepted `in_valid`

## Operation
- ADD: `data_out = data_1 + data_2` mod 2^WIDTH. `carry` = carry-out of bit WIDTH-1. `overflow` = operands same sign and result sign differs.
- SUB: `data_out = data_1 - data_2` mod 2^WIDTH, computed as `data_1 + ~data_2 + 1`. `carry` = carry-out of that sum, which is 1 iff `data_1 >= data_2` unsigned. `overflow` = operands differ in sign and result sign differs from `data_1`.
- OR: bitwise `data_1 | data_2`. `carry` = 0, `overflow` = 0.
- AND: bitwise `data_1 & data_2`. `carry` = 0, `overflow` = 0.
- `zero` and `negative` are derived from `data_out` for all ops.
- All four opcodes are defined. No X propagation for known inputs. Operands are treated as unsigned for carry and two's-complement for overflow/negative.

## Timing
- `data_out` and the combinational flags have zero-cycle latency. They are valid after settle and depend only on `alu_op`, `data_1` and `data_2`, with no clock involvement.
- On each rising `clk` edge with `rst` = 1: `res_q` = 0, `flags_q` = 0, `out_valid` = 0.
- On each rising `clk` edge with `rst` = 0:
  - `out_valid <= in_valid`.
  - If `in_valid` = 1: `res_q <= data_out` and `flags_q <= {overflow, carry, negative, zero}`.
  - If `in_valid` = 0: `res_q` and `flags_q` hold.
- Reset asserted together with `in_valid`: reset wins, nothing is captured.
- Reset has no effect on the combinational outputs.
- There is no backpressure. Back-to-back `in_valid` captures every cycle.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `ALU_ADD` = 2'b00, `ALU_SUB` = 2'b01, `ALU_OR` = 2'b10, `ALU_AND` = 2'b11
  - flag bit indices `FLG_Z` = 0, `FLG_N` = 1, `FLG_C` = 2, `FLG_V` = 3
- One sub-module, `alu_addsub`. It is a single WIDTH-bit adder with an operand-B invert and carry-in, driven by `sub`. It returns the sum, carry-out and overflow, and is shared by ADD and SUB.
- Top-level: opcode mux, flag generation, output register stage.

## Test plan
- ADD wrap: `data_1` = 0xFFFF_FFFF_FFFF_FFFF, `data_2` = 1, op 00 -> `data_out` = 0, zero = 1, carry = 1, overflow = 0.
- SUB signed overflow: `data_1` = 0x8000_0000_0000_0000, `data_2` = 1, op 01 -> `data_out` = 0x7FFF_FFFF_FFFF_FFFF, overflow = 1, carry = 1, negative = 0.
- SUB borrow: `data_1` = 3, `data_2` = 5, op 01 -> `data_out` = 0xFFFF_FFFF_FFFF_FFFE, carry = 0, negative = 1.
- Logic: `data_1` = 0xF0F0, `data_2` = 0x0FF0, op 10 -> 0xFFF0; op 11 -> 0x00F0. carry = overflow = 0 for both.
- Random: 100 iterations with random operands and op. After 1 time unit, `data_out` must equal the software model for ADD/SUB/OR/AND exactly; report a pass count of 100/100.
- Registered path:
  - Assert `rst` for 2 cycles: `res_q`, `flags_q` and `out_valid` are 0.
  - Then `in_valid` = 1 with ADD 2+3: next edge gives `res_q` = 5, `out_valid` = 1.
  - Drop `in_valid`: `res_q` holds 5 and `out_valid` = 0.
  - Assert `rst` with `in_valid` = 1: all registers clear.
